// File: rtl/bf_ctrl_pkg.sv
// Shared state codes, operand/result indices and display constants for the butterfly entry sequencer.
package bf_ctrl_pkg;

  typedef enum logic [3:0] {
    LOAD_AR   = 4'd0,
    LOAD_AI   = 4'd1,
    LOAD_BR   = 4'd2,
    LOAD_BI   = 4'd3,
    LOAD_WR   = 4'd4,
    LOAD_WI   = 4'd5,
    START     = 4'd6,
    WAIT_DONE = 4'd7,
    SHOW_XR   = 4'd8,
    SHOW_XI   = 4'd9,
    SHOW_YR   = 4'd10,
    SHOW_YI   = 4'd11,
    ERR       = 4'd15
  } state_t;

  localparam logic [2:0] OP_AR = 3'd0;
  localparam logic [2:0] OP_AI = 3'd1;
  localparam logic [2:0] OP_BR = 3'd2;
  localparam logic [2:0] OP_BI = 3'd3;
  localparam logic [2:0] OP_WR = 3'd4;
  localparam logic [2:0] OP_WI = 3'd5;

  localparam logic [1:0] RES_XR = 2'd0;
  localparam logic [1:0] RES_XI = 2'd1;
  localparam logic [1:0] RES_YR = 2'd2;
  localparam logic [1:0] RES_YI = 2'd3;

  // Sliced to the operand width at the point of use.
  localparam logic [63:0] ERR_DISP = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/bf_operand_regfile.sv
// Six-entry operand register file: one indexed write port, all entries read in parallel.
module bf_operand_regfile
  import bf_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         we,
  input  logic [2:0]   idx,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] ar,
  output logic [W-1:0] ai,
  output logic [W-1:0] br,
  output logic [W-1:0] bi,
  output logic [W-1:0] wr,
  output logic [W-1:0] wi
);

  // Indexed operand write; entries hold until explicitly overwritten.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ar <= {W{1'b0}};
      ai <= {W{1'b0}};
      br <= {W{1'b0}};
      bi <= {W{1'b0}};
      wr <= {W{1'b0}};
      wi <= {W{1'b0}};
    end else if (we) begin
      case (idx)
        OP_AR:   ar <= wdata;
        OP_AI:   ai <= wdata;
        OP_BR:   br <= wdata;
        OP_BI:   bi <= wdata;
        OP_WR:   wr <= wdata;
        OP_WI:   wi <= wdata;
        default: ar <= ar;
      endcase
    end else begin
      ar <= ar;
    end
  end

endmodule

// File: rtl/butterfly_entry_ctrl.sv
// Push-button sequencer: six operand loads, butterfly start/capture, four-result display.
// Optional wait-for-done timeout with ERR state is enabled by defining BFCTRL_TIMEOUT_EN.
module butterfly_entry_ctrl
  import bf_ctrl_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         next_pulse,
  input  logic         clear_pulse,
  input  logic [W-1:0] sw_data,
  output logic         bf_start,
  output logic [W-1:0] bf_ar,
  output logic [W-1:0] bf_ai,
  output logic [W-1:0] bf_br,
  output logic [W-1:0] bf_bi,
  output logic [W-1:0] bf_wr,
  output logic [W-1:0] bf_wi,
  input  logic         bf_done,
  input  logic [W-1:0] bf_xr,
  input  logic [W-1:0] bf_xi,
  input  logic [W-1:0] bf_yr,
  input  logic [W-1:0] bf_yi,
  output logic [W-1:0] disp_value,
  output logic [3:0]   disp_sel,
  output logic         busy,
  output logic         err
);

  state_t       state_r;
  state_t       state_nxt_s;
  logic         bf_start_r;
  logic         busy_r;
  logic [W-1:0] res_r [4];
  logic         op_we_s;
  logic         capture_s;
  logic         to_expire_s;

  // Clear always wins over an operand write landing in the same cycle.
  assign op_we_s   = next_pulse && !clear_pulse && (state_r inside {LOAD_AR, LOAD_AI, LOAD_BR,
                                                                    LOAD_BI, LOAD_WR, LOAD_WI});
  assign capture_s = bf_done && !clear_pulse && (state_r == WAIT_DONE);

  bf_operand_regfile #(.W(W)) u_regfile (
    .clk    (clk),
    .nReset (nReset),
    .we     (op_we_s),
    .idx    (state_r[2:0]),
    .wdata  (sw_data),
    .ar     (bf_ar),
    .ai     (bf_ai),
    .br     (bf_br),
    .bi     (bf_bi),
    .wr     (bf_wr),
    .wi     (bf_wi)
  );

`ifdef BFCTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] to_cnt_r;
  logic             err_r;

  assign to_expire_s = (to_cnt_r == {CNT_W{1'b0}});
  assign err         = err_r;

  // Wait-for-done down-counter, armed while leaving START.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == START) begin
      to_cnt_r <= CNT_W'(TIMEOUT - 1);
    end else if ((state_r == WAIT_DONE) && !bf_done && !to_expire_s) begin
      to_cnt_r <= to_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Error flag registered alongside the state.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_nxt_s == ERR);
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
  assign to_expire_s      = 1'b0;
  assign err              = 1'b0;
`endif

  // Next-state decode; clear_pulse aborts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (clear_pulse) begin
      state_nxt_s = LOAD_AR;
    end else begin
      case (state_r)
        LOAD_AR:   state_nxt_s = next_pulse ? LOAD_AI : LOAD_AR;
        LOAD_AI:   state_nxt_s = next_pulse ? LOAD_BR : LOAD_AI;
        LOAD_BR:   state_nxt_s = next_pulse ? LOAD_BI : LOAD_BR;
        LOAD_BI:   state_nxt_s = next_pulse ? LOAD_WR : LOAD_BI;
        LOAD_WR:   state_nxt_s = next_pulse ? LOAD_WI : LOAD_WR;
        LOAD_WI:   state_nxt_s = next_pulse ? START   : LOAD_WI;
        START:     state_nxt_s = WAIT_DONE;
        WAIT_DONE: begin
          if (bf_done) begin
            state_nxt_s = SHOW_XR;
          end else if (to_expire_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = WAIT_DONE;
          end
        end
        SHOW_XR:   state_nxt_s = next_pulse ? SHOW_XI : SHOW_XR;
        SHOW_XI:   state_nxt_s = next_pulse ? SHOW_YR : SHOW_XI;
        SHOW_YR:   state_nxt_s = next_pulse ? SHOW_YI : SHOW_YR;
        SHOW_YI:   state_nxt_s = next_pulse ? LOAD_AR : SHOW_YI;
`ifdef BFCTRL_TIMEOUT_EN
        ERR:       state_nxt_s = ERR;
`endif
        default:   state_nxt_s = LOAD_AR;
      endcase
    end
  end

  // State register with its registered strobes.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r    <= LOAD_AR;
      bf_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bf_start_r <= (state_nxt_s == START);
      busy_r     <= (state_nxt_s == START) || (state_nxt_s == WAIT_DONE);
    end
  end

  // Result capture; clear discards a coincident bf_done.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 4; i++) res_r[i] <= {W{1'b0}};
    end else if (clear_pulse) begin
      for (int i = 0; i < 4; i++) res_r[i] <= {W{1'b0}};
    end else if (capture_s) begin
      res_r[RES_XR] <= bf_xr;
      res_r[RES_XI] <= bf_xi;
      res_r[RES_YR] <= bf_yr;
      res_r[RES_YI] <= bf_yi;
    end else begin
      res_r[RES_XR] <= res_r[RES_XR];
    end
  end

  // Display mux: live switch echo while loading, captured results while showing.
  always_comb begin
    disp_value = {W{1'b0}};
    case (state_r)
      LOAD_AR, LOAD_AI, LOAD_BR,
      LOAD_BI, LOAD_WR, LOAD_WI: disp_value = sw_data;
      SHOW_XR:                   disp_value = res_r[RES_XR];
      SHOW_XI:                   disp_value = res_r[RES_XI];
      SHOW_YR:                   disp_value = res_r[RES_YR];
      SHOW_YI:                   disp_value = res_r[RES_YI];
      ERR:                       disp_value = ERR_DISP[W-1:0];
      default:                   disp_value = {W{1'b0}};
    endcase
  end

  assign disp_sel = state_r;
  assign bf_start = bf_start_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_butterfly_entry_ctrl.sv
// Self-checking bench: directed scenarios plus random button/done traffic against a step-counter model.
module tb_butterfly_entry_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       nReset;
  logic       next_pulse, clear_pulse, bf_done;
  logic [7:0] sw_data;
  logic       bf_start, busy, err;
  logic [7:0] bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi;
  logic [7:0] bf_xr, bf_xi, bf_yr, bf_yi;
  logic [7:0] disp_value;
  logic [3:0] disp_sel;

  int checks = 0;
  int errors = 0;

  // Reference model: step index 0-5 loads, 6 start, 7 wait, 8-11 show, 15 error.
  int         m_step;
  int         m_wait;
  logic [7:0] m_ops [6];
  logic [7:0] m_res [4];
  logic [7:0] m_sw;
  logic [7:0] saved;

  always #5 clk = ~clk;

  butterfly_entry_ctrl #(.W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .nReset(nReset), .next_pulse(next_pulse), .clear_pulse(clear_pulse),
    .sw_data(sw_data), .bf_start(bf_start),
    .bf_ar(bf_ar), .bf_ai(bf_ai), .bf_br(bf_br), .bf_bi(bf_bi), .bf_wr(bf_wr), .bf_wi(bf_wi),
    .bf_done(bf_done), .bf_xr(bf_xr), .bf_xi(bf_xi), .bf_yr(bf_yr), .bf_yi(bf_yi),
    .disp_value(disp_value), .disp_sel(disp_sel), .busy(busy), .err(err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_step = 0;
    m_wait = 0;
    for (int i = 0; i < 6; i++) m_ops[i] = 8'h00;
    for (int i = 0; i < 4; i++) m_res[i] = 8'h00;
  endtask

  task automatic model_apply(input logic nx, input logic cl, input logic dn, input logic [7:0] sw,
                             input logic [7:0] xr, input logic [7:0] xi,
                             input logic [7:0] yr, input logic [7:0] yi);
    if (cl) begin
      m_step = 0;
      for (int i = 0; i < 4; i++) m_res[i] = 8'h00;
    end else if (m_step < 6) begin
      if (nx) begin
        m_ops[m_step] = sw;
        m_step++;
      end
    end else if (m_step == 6) begin
      m_step = 7;
      m_wait = 0;
    end else if (m_step == 7) begin
      if (dn) begin
        m_res[0] = xr; m_res[1] = xi; m_res[2] = yr; m_res[3] = yi;
        m_step = 8;
      end
`ifdef BFCTRL_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TO) m_step = 15;
      end
`endif
    end else if (m_step <= 11) begin
      if (nx) m_step = (m_step == 11) ? 0 : m_step + 1;
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_disp;
    if (m_step < 6)                       exp_disp = m_sw;
    else if (m_step >= 8 && m_step <= 11) exp_disp = m_res[m_step-8];
    else if (m_step == 15)                exp_disp = 8'hFF;
    else                                  exp_disp = 8'h00;
    check_val("disp_sel", disp_sel, m_step);
    check_val("disp_value", disp_value, exp_disp);
    check_val("bf_start", bf_start, (m_step == 6));
    check_val("busy", busy, (m_step == 6 || m_step == 7));
    check_val("err", err, (m_step == 15));
    check_val("bf_ar", bf_ar, m_ops[0]);
    check_val("bf_ai", bf_ai, m_ops[1]);
    check_val("bf_br", bf_br, m_ops[2]);
    check_val("bf_bi", bf_bi, m_ops[3]);
    check_val("bf_wr", bf_wr, m_ops[4]);
    check_val("bf_wi", bf_wi, m_ops[5]);
  endtask

  // Drive one clock's worth of inputs (called just after a falling edge), then check at the next.
  task automatic cyc(input logic nx, input logic cl, input logic dn, input logic [7:0] sw,
                     input logic [7:0] xr, input logic [7:0] xi,
                     input logic [7:0] yr, input logic [7:0] yi);
    next_pulse = nx; clear_pulse = cl; bf_done = dn; sw_data = sw;
    bf_xr = xr; bf_xi = xi; bf_yr = yr; bf_yi = yi;
    m_sw = sw;
    model_apply(nx, cl, dn, sw, xr, xi, yr, yi);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, m_sw, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic nxt(input logic [7:0] sw);
    cyc(1'b1, 1'b0, 1'b0, sw, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    nReset = 1'b0; next_pulse = 1'b0; clear_pulse = 1'b0; bf_done = 1'b0;
    sw_data = 8'h3C; bf_xr = 8'h00; bf_xi = 8'h00; bf_yr = 8'h00; bf_yi = 8'h00;
    m_sw = 8'h3C;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    nReset = 1'b1;

    // Operand entry and start strobe
    nxt(8'h10); nxt(8'h00); nxt(8'h08); nxt(8'h00); nxt(8'h7F); nxt(8'h00);
    check_val("t1_start", bf_start, 1'b1);
    check_val("t1_ar", bf_ar, 8'h10);
    check_val("t1_br", bf_br, 8'h08);
    check_val("t1_wr", bf_wr, 8'h7F);

    // Done after wait, then walk the results
    idle(4);
    check_val("t1_start_once", bf_start, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h21, 8'h18, 8'h00, 8'h08, 8'h00);
    check_val("t2_xr", disp_value, 8'h18);
    nxt(8'h21); check_val("t2_xi", disp_value, 8'h00);
    nxt(8'h21); check_val("t2_yr", disp_value, 8'h08);
    nxt(8'h21); check_val("t2_yi", disp_value, 8'h00);
    nxt(8'h42); check_val("t2_back", disp_sel, 4'd0);
    check_val("t2_live", disp_value, 8'h42);

    // Next and clear together in LOAD_BI
    nxt(8'h01); nxt(8'h02); nxt(8'h03);
    saved = bf_bi;
    cyc(1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
    check_val("t3_state", disp_sel, 4'd0);
    check_val("t3_bi", bf_bi, saved);

    // Next pulses ignored while waiting; stray done ignored while loading
    for (int i = 0; i < 6; i++) nxt(8'(8'hA0 + i));
    idle(1);
    nxt(8'h11); nxt(8'h12); nxt(8'h13);
    check_val("t4_wait", disp_sel, 4'd7);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h91, 8'h92, 8'h93, 8'h94);
    nxt(8'h00); nxt(8'h00); nxt(8'h00); nxt(8'h00);
    nxt(8'h5A);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    check_val("t4_stray", disp_sel, 4'd1);

`ifdef BFCTRL_TIMEOUT_EN
    // Timeout into ERR, exit by clear; done on the terminal cycle still wins
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) nxt(8'(i));
    idle(TO + 1);
    check_val("t5_err", err, 1'b1);
    check_val("t5_disp", disp_value, 8'hFF);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_val("t5_clr", err, 1'b0);
    for (int i = 0; i < 6; i++) nxt(8'(i));
    idle(TO);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 8'h00, 8'h00, 8'h00);
    check_val("t5_term", disp_sel, 4'd8);
    check_val("t5_term_err", err, 1'b0);
`endif

    // Async reset while waiting
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) nxt(8'(8'h30 + i));
    idle(2);
    #2 nReset = 1'b0;
    #1;
    model_reset();
    check_val("t6_sel", disp_sel, 4'd0);
    check_val("t6_busy", busy, 1'b0);
    check_val("t6_ar", bf_ar, 8'h00);
    check_val("t6_disp", disp_value, sw_data);
    @(negedge clk);
    nReset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 8'h66, 8'h12, 8'h34, 8'h56, 8'h78);
    check_val("t6_done_ignored", disp_sel, 4'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 3) == 0, ($urandom % 25) == 0, ($urandom % 5) == 0, 8'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
